// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - instruction fetch bus between sequencer and memory
interface instr_sequencer_if;
   logic        mem_req;
   logic [11:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_data;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - MCT instruction sequencer: fetch with odd parity and watchdog, timed execute, branch redirect
module instr_sequencer #(
   parameter int MCT_PHASES = 12,
   parameter int TIMEOUT    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      run,
   input  logic                      branch_valid,
   input  logic [11:0]               branch_addr,
   instr_sequencer_if.master         mem,
   output logic [14:0]               instr,
   output logic                      instr_tp,
   output logic [3:0]                tp_phase,
   output logic                      parity_err,
   output logic                      timeout_err
);
   localparam int WDW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

   state_t          r_state, w_next;
   logic [11:0]     r_z, r_pend_addr;
   logic            r_pend_valid;
   logic [14:0]     r_instr;
   logic            r_instr_tp;
   logic [3:0]      r_phase;
   logic [WDW-1:0]  r_wdog;
   logic            r_parity_err, r_timeout_err;
   logic            w_fetch_ok, w_fetch_bad, w_timeout, w_mct_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_fetch_ok   = 1'b0;
      w_fetch_bad  = 1'b0;
      w_timeout    = 1'b0;
      w_mct_end    = 1'b0;
      mem.mem_req  = (r_state == S_FETCH);
      mem.mem_addr = r_z;
      case (r_state)
         S_IDLE:  if (run) w_next = S_FETCH;
         S_FETCH: begin
            // An ack on the watchdog's last cycle wins over the timeout.
            if (mem.mem_ack) begin
               if (^mem.mem_data) begin
                  w_fetch_ok = 1'b1;
                  w_next     = S_EXEC;
               end else begin
                  w_fetch_bad = 1'b1;
                  w_next      = S_HALT;
               end
            end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
               w_timeout = 1'b1;
               w_next    = S_HALT;
            end
         end
         S_EXEC: begin
            if (r_phase == 4'(MCT_PHASES)) begin
               w_mct_end = 1'b1;
               w_next    = run ? S_FETCH : S_IDLE;
            end
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_z           <= '0;
         r_pend_addr   <= '0;
         r_pend_valid  <= 1'b0;
         r_instr       <= '0;
         r_instr_tp    <= 1'b0;
         r_phase       <= '0;
         r_wdog        <= '0;
         r_parity_err  <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_instr_tp <= w_fetch_ok;
         case (r_state)
            S_IDLE: begin
               if (run) begin
                  r_phase <= 4'd1;
                  r_wdog  <= '0;
               end
            end
            S_FETCH: begin
               if (w_fetch_ok) begin
                  r_instr <= mem.mem_data[14:0];
                  r_z     <= r_z + 12'd1;
                  r_phase <= 4'd2;
               end else if (w_fetch_bad) begin
                  r_parity_err <= 1'b1;
                  r_phase      <= '0;
               end else if (w_timeout) begin
                  r_timeout_err <= 1'b1;
                  r_phase       <= '0;
               end else if (!mem.mem_ack) begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            S_EXEC: begin
               if (w_mct_end) begin
                  // A request landing on the final phase still redirects this MCT.
                  if (branch_valid)      r_z <= branch_addr;
                  else if (r_pend_valid) r_z <= r_pend_addr;
                  r_pend_valid <= 1'b0;
                  r_phase      <= run ? 4'd1 : 4'd0;
                  r_wdog       <= '0;
               end else begin
                  r_phase <= r_phase + 4'd1;
                  if (branch_valid) begin
                     r_pend_valid <= 1'b1;
                     r_pend_addr  <= branch_addr;
                  end
               end
            end
            default: r_phase <= '0;
         endcase
      end
   end

   assign instr       = r_instr;
   assign instr_tp    = r_instr_tp;
   assign tp_phase    = r_phase;
   assign parity_err  = r_parity_err;
   assign timeout_err = r_timeout_err;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        branch_valid;
   logic [11:0] branch_addr;
   logic [14:0] instr;
   logic        instr_tp;
   logic [3:0]  tp_phase;
   logic        parity_err;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;
   logic [14:0] exp_q[$];
   logic        prev_tp = 1'b0;

   instr_sequencer_if bus ();

   instr_sequencer #(.MCT_PHASES(12), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .branch_valid(branch_valid), .branch_addr(branch_addr),
      .mem(bus),
      .instr(instr), .instr_tp(instr_tp), .tp_phase(tp_phase),
      .parity_err(parity_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && instr_tp) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL instr_tp_unexpected: got strobe with instr=%h, expected no strobe", instr);
         end else begin
            logic [14:0] e;
            e = exp_q.pop_front();
            if (instr !== e || prev_tp) begin
               errors++;
               $display("FAIL instr_word: got instr=%h prev_tp=%b, expected instr=%h prev_tp=0", instr, prev_tp, e);
            end
         end
      end
      prev_tp = rst_n && instr_tp;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, expected completion");
      $fatal(1);
   end

   task automatic wait_fetch(output int n);
      n = 0;
      while (!bus.mem_req && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic give_ack(input logic [15:0] d, input int delay);
      repeat (delay) @(negedge clk);
      bus.mem_ack  = 1'b1;
      bus.mem_data = d;
      if (^d) exp_q.push_back(d[14:0]);
      @(negedge clk);
      bus.mem_ack  = 1'b0;
      bus.mem_data = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b0; branch_valid = 1'b0; branch_addr = '0;
      bus.mem_ack = 1'b0; bus.mem_data = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_addr, instr, instr_tp, tp_phase, parity_err, timeout_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got req=%b addr=%h instr=%h tp=%b ph=%0d perr=%b terr=%b, expected all 0",
                  bus.mem_req, bus.mem_addr, instr, instr_tp, tp_phase, parity_err, timeout_err);
      end
   endtask

   task automatic test_basic();
      int n;
      run = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h000 || tp_phase !== 4'd1) begin
         errors++;
         $display("FAIL first_fetch: got req=%b addr=%h ph=%0d, expected req=1 addr=000 ph=1", bus.mem_req, bus.mem_addr, tp_phase);
      end
      give_ack(16'h6B11, 0);
      checks++;
      if (tp_phase !== 4'd2 || bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL exec_entry: got ph=%0d req=%b, expected ph=2 req=0", tp_phase, bus.mem_req);
      end
      n = 1;
      while (!bus.mem_req && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 12 || bus.mem_addr !== 12'h001 || tp_phase !== 4'd1) begin
         errors++;
         $display("FAIL mct_length: got clocks=%0d addr=%h ph=%0d, expected clocks=12 addr=001 ph=1", n, bus.mem_addr, tp_phase);
      end
   endtask

   task automatic test_branch();
      int n;
      give_ack(16'h0001, 15);
      checks++;
      if (timeout_err !== 1'b0 || tp_phase !== 4'd2) begin
         errors++;
         $display("FAIL ack_on_last_cycle: got terr=%b ph=%0d, expected terr=0 ph=2", timeout_err, tp_phase);
      end
      @(negedge clk);
      branch_valid = 1'b1; branch_addr = 12'h100;
      @(negedge clk);
      branch_valid = 1'b0;
      repeat (2) @(negedge clk);
      branch_valid = 1'b1; branch_addr = 12'h2A5;
      @(negedge clk);
      branch_valid = 1'b0;
      wait_fetch(n);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h2A5) begin
         errors++;
         $display("FAIL branch_last_wins: got req=%b addr=%h, expected req=1 addr=2a5", bus.mem_req, bus.mem_addr);
      end
   endtask

   task automatic test_wrap();
      int n;
      give_ack(16'h0007, 0);
      @(negedge clk);
      branch_valid = 1'b1; branch_addr = 12'hFFF;
      @(negedge clk);
      branch_valid = 1'b0;
      wait_fetch(n);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'hFFF) begin
         errors++;
         $display("FAIL branch_to_fff: got req=%b addr=%h, expected req=1 addr=fff", bus.mem_req, bus.mem_addr);
      end
      branch_valid = 1'b1; branch_addr = 12'h3FF;
      @(negedge clk);
      branch_valid = 1'b0;
      give_ack(16'h000B, 1);
      wait_fetch(n);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h000) begin
         errors++;
         $display("FAIL z_wrap_fetch_branch_ignored: got req=%b addr=%h, expected req=1 addr=000", bus.mem_req, bus.mem_addr);
      end
   endtask

   task automatic test_run_drop();
      int n;
      give_ack(16'h4000, 0);
      repeat (3) @(negedge clk);
      checks++;
      if (tp_phase !== 4'd5) begin
         errors++;
         $display("FAIL phase_five: got ph=%0d, expected ph=5", tp_phase);
      end
      run = 1'b0;
      n = 0;
      while (tp_phase !== 4'd12 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 7 || bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL run_drop_completes: got clocks_to_ph12=%0d req=%b, expected 7 req=0", n, bus.mem_req);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (tp_phase !== 4'd0 || bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_drop: got ph=%0d req=%b, expected ph=0 req=0", tp_phase, bus.mem_req);
      end
      run = 1'b1;
      wait_fetch(n);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h001 || n != 1) begin
         errors++;
         $display("FAIL restart_fetch: got req=%b addr=%h clocks=%0d, expected req=1 addr=001 clocks=1", bus.mem_req, bus.mem_addr, n);
      end
   endtask

   task automatic test_async_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_addr, instr, instr_tp, tp_phase, parity_err, timeout_err} !== '0) begin
         errors++;
         $display("FAIL async_reset: got req=%b addr=%h instr=%h ph=%0d, expected all 0", bus.mem_req, bus.mem_addr, instr, tp_phase);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_parity();
      int n;
      @(negedge clk);
      give_ack(16'h0010, 0);
      wait_fetch(n);
      checks++;
      if (bus.mem_addr !== 12'h001) begin
         errors++;
         $display("FAIL parity_setup_addr: got addr=%h, expected addr=001", bus.mem_addr);
      end
      give_ack(16'hEB11, 0);
      checks++;
      if (parity_err !== 1'b1 || bus.mem_req !== 1'b0 || tp_phase !== 4'd0 || instr !== 15'h0010) begin
         errors++;
         $display("FAIL parity_halt: got perr=%b req=%b ph=%0d instr=%h, expected perr=1 req=0 ph=0 instr=0010",
                  parity_err, bus.mem_req, tp_phase, instr);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (parity_err !== 1'b1 || bus.mem_req !== 1'b0 || tp_phase !== 4'd0) begin
         errors++;
         $display("FAIL halt_sticky: got perr=%b req=%b ph=%0d, expected perr=1 req=0 ph=0", parity_err, bus.mem_req, tp_phase);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (parity_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_cleared: got perr=%b, expected perr=0", parity_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_timeout();
      @(negedge clk);
      repeat (15) @(negedge clk);
      checks++;
      if (timeout_err !== 1'b0 || bus.mem_req !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: got terr=%b req=%b at cycle 16, expected terr=0 req=1", timeout_err, bus.mem_req);
      end
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b1 || bus.mem_req !== 1'b0 || tp_phase !== 4'd0 || parity_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_halt: got terr=%b req=%b ph=%0d perr=%b, expected terr=1 req=0 ph=0 perr=0",
                  timeout_err, bus.mem_req, tp_phase, parity_err);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_branch();
      test_wrap();
      test_run_drop();
      test_async_reset();
      test_parity();
      test_timeout();
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending words, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter MCT_PHASES, default 12, timing phases per memory cycle time (MCT).
REQ-002 Parameter TIMEOUT, default 16, maximum FETCH cycles without mem_ack before halt.
REQ-003 Single clock domain; reset asynchronous, active-low; all state clears on rst_n low.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 run  input  1  level; 1 = keep sequencing MCTs, 0 = stop at end of current MCT.
REQ-007 branch_valid  input  1  one-cycle request to redirect next fetch.
REQ-008 branch_addr  input  12  target address, sampled with branch_valid.
REQ-009 mem_req  output  1  fetch request to fixed/erasable memory.
REQ-010 mem_addr  output  12  fetch address; always equals Z.
REQ-011 mem_ack  input  1  memory word valid this cycle; meaningful only while mem_req=1.
REQ-012 mem_data  input  16  bit 15 parity, bits 14:0 instruction word.
REQ-013 instr  output  15  last good instruction word, held until next good fetch.
REQ-014 instr_tp  output  1  one-cycle strobe, high the cycle after instr updates; drives the decoder's tp.
REQ-015 tp_phase  output  4  current timing phase 1..MCT_PHASES; 0 when idle/halted.
REQ-016 parity_err  output  1  sticky, fetched word failed odd parity.
REQ-017 timeout_err  output  1  sticky, mem_ack not received within TIMEOUT cycles.

Function
REQ-018 States: IDLE, FETCH, EXEC, HALT; Z is a 12-bit program counter register.
REQ-019 IDLE: outputs idle; run=1 at edge -> FETCH, tp_phase=1, watchdog=0.
REQ-020 FETCH: mem_req=1, mem_addr=Z, tp_phase held at 1; watchdog increments each cycle without ack.
REQ-021 FETCH with mem_ack=1 and odd popcount of mem_data[15:0]: instr<=mem_data[14:0], instr_tp=1 next cycle, Z<=Z+1 (12'hFFF wraps to 12'h000), -> EXEC, tp_phase=2.
REQ-022 FETCH with mem_ack=1 and even popcount: parity_err<=1, instr and Z unchanged, no instr_tp, -> HALT.
REQ-023 FETCH, TIMEOUT-th consecutive cycle with mem_ack=0: timeout_err<=1, -> HALT; ack on that same edge takes precedence over timeout.
REQ-024 EXEC: mem_req=0; tp_phase increments by 1 per cycle up to MCT_PHASES.
REQ-025 EXEC branch_valid=1: capture branch_addr into pending register; multiple requests in one MCT, last wins; branch_valid in IDLE/FETCH/HALT ignored.
REQ-026 End of phase MCT_PHASES: if pending branch, Z<=captured address (overrides increment) and pending clears.
REQ-027 End of phase MCT_PHASES: run=1 -> FETCH (tp_phase=1, watchdog=0); run=0 -> IDLE (tp_phase=0).
REQ-028 Minimum MCT with same-cycle ack: exactly MCT_PHASES clocks from FETCH entry to next FETCH entry.
REQ-029 HALT: mem_req=0, tp_phase=0, errors held; exit only via rst_n.
REQ-030 run deasserted during FETCH/EXEC has no effect until end of MCT.

Reset
REQ-031 rst_n low, any state including mid-FETCH: state=IDLE, Z=0, instr=0, pending branch cleared, watchdog=0, all outputs 0, within same cycle (asynchronous).
REQ-032 rst_n release: first transition possible on the next rising edge.

Verification
REQ-033 Reset, run=1, mem_ack=1 immediately, mem_data=16'h6B11 -> mem_addr=0, instr=15'h6B11 (OpCode 110, QC 10), instr_tp one cycle, next FETCH addr=1 exactly 12 clocks later.
REQ-034 Z=12'hFFF, good fetch -> next mem_addr=12'h000.
REQ-035 mem_data=16'hEB11 -> parity_err=1, HALT, instr unchanged, mem_req=0, no instr_tp; only rst_n recovers.
REQ-036 mem_ack held 0 -> timeout_err=1 after 16 FETCH cycles; ack on 16th cycle -> no error, normal EXEC.
REQ-037 Two branch_valid in one EXEC (addr 12'h100 then 12'h2A5) -> next mem_addr=12'h2A5; branch_valid during FETCH ignored.
REQ-038 run dropped at phase 5 -> MCT completes to phase 12, then IDLE, tp_phase=0; rst_n pulsed mid-FETCH -> all outputs 0 immediately.
